// File: rtl/lsu_issue_queue.sv
// In-order LSU issue queue: holds dispatched memory uOPs, tracks operand readiness via PRF
// wakeups and hands the oldest ready entry to the LSU without ever reordering.
module lsu_issue_queue #(
   parameter int DEPTH     = 8,
   parameter int PAYLOAD_W = 128,
   parameter int TAG_W     = 7,
   parameter int WK_N      = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_flush,
   input  logic [1:0]                 i_enq_valid,
   input  logic [2*PAYLOAD_W-1:0]     i_enq_payload,
   input  logic [4*TAG_W-1:0]         i_enq_rs_tag,
   input  logic [3:0]                 i_enq_rs_rdy,
   output logic                       o_enq_ready,
   input  logic [WK_N-1:0]            i_wk_valid,
   input  logic [WK_N*TAG_W-1:0]      i_wk_tag,
   input  logic                       i_lsu_busy,
   output logic                       o_issue_valid,
   output logic [PAYLOAD_W-1:0]       o_issue_payload,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam logic [PTR_W-1:0] ENQ_LIMIT = PTR_W'(DEPTH - 2);

   function automatic logic f_wk_hit(
      input logic [TAG_W-1:0]      tag,
      input logic [WK_N-1:0]       vld,
      input logic [WK_N*TAG_W-1:0] tags
   );
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < WK_N; k++) begin
         if (vld[k] && (tags[k*TAG_W +: TAG_W] == tag)) hit = 1'b1;
      end
      return hit;
   endfunction

   logic [PAYLOAD_W-1:0] r_payload [DEPTH];
   logic [TAG_W-1:0]     r_tag0    [DEPTH];
   logic [TAG_W-1:0]     r_tag1    [DEPTH];
   logic [DEPTH-1:0]     r_valid;
   logic [DEPTH-1:0]     r_rdy0;
   logic [DEPTH-1:0]     r_rdy1;
   logic [PTR_W-1:0]     r_head;
   logic [PTR_W-1:0]     r_tail;
   logic [PTR_W-1:0]     r_count;

   logic [IDX_W-1:0]     w_head_idx;
   logic [IDX_W-1:0]     w_tail_idx0;
   logic [IDX_W-1:0]     w_tail_idx1;
   logic                 w_empty;
   logic                 w_enq_accept;
   logic                 w_enq0;
   logic                 w_enq1;
   logic [1:0]           w_enq_num;
   logic                 w_issue;
   logic [DEPTH-1:0]     w_wake0;
   logic [DEPTH-1:0]     w_wake1;
   logic [1:0]           w_slot_rdy0;
   logic [1:0]           w_slot_rdy1;
   logic [DEPTH-1:0]     w_valid_nxt;
   logic [DEPTH-1:0]     w_rdy0_nxt;
   logic [DEPTH-1:0]     w_rdy1_nxt;

   assign w_head_idx  = r_head[IDX_W-1:0];
   assign w_tail_idx0 = r_tail[IDX_W-1:0];
   assign w_tail_idx1 = w_tail_idx0 + IDX_W'(1);
   assign w_empty     = (r_head == r_tail);

   // Admission looks only at the registered count so dispatch never waits on the issue path.
   assign o_enq_ready  = (r_count <= ENQ_LIMIT);
   assign w_enq_accept = o_enq_ready & ~i_flush;
   assign w_enq0       = w_enq_accept & i_enq_valid[0];
   assign w_enq1       = w_enq_accept & i_enq_valid[0] & i_enq_valid[1];
   assign w_enq_num    = {1'b0, w_enq0} + {1'b0, w_enq1};

   assign w_issue         = ~w_empty & r_rdy0[w_head_idx] & r_rdy1[w_head_idx] & ~i_lsu_busy & ~i_flush;
   assign o_issue_valid   = w_issue;
   assign o_issue_payload = r_payload[w_head_idx];
   assign o_count         = r_count;

   always_comb begin
      w_wake0     = '0;
      w_wake1     = '0;
      w_slot_rdy0 = '0;
      w_slot_rdy1 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_wake0[i] = r_valid[i] & f_wk_hit(r_tag0[i], i_wk_valid, i_wk_tag);
         w_wake1[i] = r_valid[i] & f_wk_hit(r_tag1[i], i_wk_valid, i_wk_tag);
      end
      // A wakeup in the dispatch cycle would otherwise be lost, since the busy table missed it.
      for (int s = 0; s < 2; s++) begin
         w_slot_rdy0[s] = i_enq_rs_rdy[2*s] |
                          f_wk_hit(i_enq_rs_tag[s*2*TAG_W +: TAG_W], i_wk_valid, i_wk_tag);
         w_slot_rdy1[s] = i_enq_rs_rdy[2*s+1] |
                          f_wk_hit(i_enq_rs_tag[s*2*TAG_W+TAG_W +: TAG_W], i_wk_valid, i_wk_tag);
      end
   end

   always_comb begin
      w_valid_nxt = r_valid;
      w_rdy0_nxt  = r_rdy0 | w_wake0;
      w_rdy1_nxt  = r_rdy1 | w_wake1;
      if (w_issue) begin
         w_valid_nxt[w_head_idx] = 1'b0;
         w_rdy0_nxt[w_head_idx]  = 1'b0;
         w_rdy1_nxt[w_head_idx]  = 1'b0;
      end
      if (w_enq0) begin
         w_valid_nxt[w_tail_idx0] = 1'b1;
         w_rdy0_nxt[w_tail_idx0]  = w_slot_rdy0[0];
         w_rdy1_nxt[w_tail_idx0]  = w_slot_rdy1[0];
      end
      if (w_enq1) begin
         w_valid_nxt[w_tail_idx1] = 1'b1;
         w_rdy0_nxt[w_tail_idx1]  = w_slot_rdy0[1];
         w_rdy1_nxt[w_tail_idx1]  = w_slot_rdy1[1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
         r_rdy0  <= '0;
         r_rdy1  <= '0;
      end else if (i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
         r_rdy0  <= '0;
         r_rdy1  <= '0;
      end else begin
         r_head  <= r_head + PTR_W'(w_issue);
         r_tail  <= r_tail + PTR_W'(w_enq_num);
         r_count <= r_count + PTR_W'(w_enq_num) - PTR_W'(w_issue);
         r_valid <= w_valid_nxt;
         r_rdy0  <= w_rdy0_nxt;
         r_rdy1  <= w_rdy1_nxt;
      end
   end

   // Payload and tags are qualified by r_valid, so they need no reset.
   always_ff @(posedge clk) begin
      if (w_enq0) begin
         r_payload[w_tail_idx0] <= i_enq_payload[0 +: PAYLOAD_W];
         r_tag0[w_tail_idx0]    <= i_enq_rs_tag[0 +: TAG_W];
         r_tag1[w_tail_idx0]    <= i_enq_rs_tag[TAG_W +: TAG_W];
      end
      if (w_enq1) begin
         r_payload[w_tail_idx1] <= i_enq_payload[PAYLOAD_W +: PAYLOAD_W];
         r_tag0[w_tail_idx1]    <= i_enq_rs_tag[2*TAG_W +: TAG_W];
         r_tag1[w_tail_idx1]    <= i_enq_rs_tag[3*TAG_W +: TAG_W];
      end
   end

endmodule

// File: tb/tb_lsu_issue_queue.sv
// Scoreboard bench for lsu_issue_queue: enqueues push expected payloads, a negedge monitor
// pops and compares on every issue, and directed checks cover count/ready/issue boundaries.
module tb_lsu_issue_queue;

   localparam int DEPTH     = 8;
   localparam int PAYLOAD_W = 128;
   localparam int TAG_W     = 7;
   localparam int WK_N      = 4;

   logic                    clk;
   logic                    rst_n;
   logic                    flush;
   logic [1:0]              enqValid;
   logic [2*PAYLOAD_W-1:0]  enqPayload;
   logic [4*TAG_W-1:0]      enqRsTag;
   logic [3:0]              enqRsRdy;
   logic                    enqReady;
   logic [WK_N-1:0]         wkValid;
   logic [WK_N*TAG_W-1:0]   wkTag;
   logic                    lsuBusy;
   logic                    issueValid;
   logic [PAYLOAD_W-1:0]    issuePayload;
   logic [3:0]              count;

   logic [PAYLOAD_W-1:0]    sbq [$];
   int                      nCompared;
   int                      nMismatched;

   lsu_issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W), .TAG_W(TAG_W), .WK_N(WK_N)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_flush         (flush),
      .i_enq_valid     (enqValid),
      .i_enq_payload   (enqPayload),
      .i_enq_rs_tag    (enqRsTag),
      .i_enq_rs_rdy    (enqRsRdy),
      .o_enq_ready     (enqReady),
      .i_wk_valid      (wkValid),
      .i_wk_tag        (wkTag),
      .i_lsu_busy      (lsuBusy),
      .o_issue_valid   (issueValid),
      .o_issue_payload (issuePayload),
      .o_count         (count)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something wedges despite the bounded waits.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Monitor: every issued uOP must be the oldest outstanding expected payload.
   always @(negedge clk) begin
      if (rst_n && issueValid === 1'b1) begin
         nCompared++;
         if (sbq.size() == 0) begin
            nMismatched++;
            $display("[TB] FAIL unexpected_issue: got %h expected no issue", issuePayload);
         end else begin
            logic [PAYLOAD_W-1:0] exp;
            exp = sbq.pop_front();
            if (issuePayload !== exp) begin
               nMismatched++;
               $display("[TB] FAIL issue_payload: got %h expected %h", issuePayload, exp);
            end
         end
      end
   end

   function automatic logic [PAYLOAD_W-1:0] mkPay(input int id);
      return {32'hA5A5_0000 | 32'(id), 32'(id * 3), 32'hDEAD_BEEF, 32'(id)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clearEnq();
      enqValid   = 2'b00;
      enqPayload = '0;
      enqRsTag   = '0;
      enqRsRdy   = '0;
   endtask

   // One slot-0 enqueue for one cycle; accepted says whether it should enter the queue.
   task automatic applyStimulus(input logic [PAYLOAD_W-1:0] p, input logic [TAG_W-1:0] t0,
                                input logic [TAG_W-1:0] t1, input logic [1:0] rdy, input bit accepted);
      enqValid   = 2'b01;
      enqPayload = {{PAYLOAD_W{1'b0}}, p};
      enqRsTag   = {{(2*TAG_W){1'b0}}, t1, t0};
      enqRsRdy   = {2'b00, rdy};
      if (accepted) sbq.push_back(p);
      tick();
      clearEnq();
   endtask

   // Dual-slot enqueue of two fully ready uOPs.
   task automatic applyPair(input logic [PAYLOAD_W-1:0] p0, input logic [PAYLOAD_W-1:0] p1,
                            input bit accepted);
      enqValid   = 2'b11;
      enqPayload = {p1, p0};
      enqRsTag   = '0;
      enqRsRdy   = 4'b1111;
      if (accepted) begin
         sbq.push_back(p0);
         sbq.push_back(p1);
      end
      tick();
      clearEnq();
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while (sbq.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      nCompared++;
      if (sbq.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL drain_timeout: got %0d outstanding expected 0", sbq.size());
         sbq.delete();
      end
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      rst_n   = 1'b0;
      flush   = 1'b0;
      wkValid = '0;
      wkTag   = '0;
      lsuBusy = 1'b0;
      clearEnq();

      // Reset state
      #12;
      checkOutput("reset_count", 32'(count), 32'd0);
      checkOutput("reset_enq_ready", 32'(enqReady), 32'd1);
      checkOutput("reset_issue_valid", 32'(issueValid), 32'd0);
      #11;
      rst_n = 1'b1;
      tick();

      // Single ready uOP issues the cycle after enqueue
      applyStimulus(mkPay(1), 7'd0, 7'd0, 2'b11, 1'b1);
      checkOutput("t1_issue_valid", 32'(issueValid), 32'd1);
      checkOutput("t1_count_one", 32'(count), 32'd1);
      waitDrain(5);
      checkOutput("t1_count_zero", 32'(count), 32'd0);

      // Not-ready head blocks a ready younger entry until its wakeup
      applyStimulus(mkPay(2), 7'd5, 7'd1, 2'b10, 1'b1);
      applyStimulus(mkPay(3), 7'd0, 7'd0, 2'b11, 1'b1);
      tick();
      tick();
      checkOutput("t2_blocked_issue", 32'(issueValid), 32'd0);
      checkOutput("t2_blocked_count", 32'(count), 32'd2);
      wkValid = 4'b0001;
      wkTag   = '0;
      wkTag[0 +: TAG_W] = 7'd5;
      tick();
      wkValid = '0;
      wkTag   = '0;
      checkOutput("t2_woken_issue", 32'(issueValid), 32'd1);
      waitDrain(6);
      checkOutput("t2_count_zero", 32'(count), 32'd0);

      // Wakeup in the dispatch cycle must be captured
      wkValid = 4'b0100;
      wkTag   = '0;
      wkTag[2*TAG_W +: TAG_W] = 7'd9;
      applyStimulus(mkPay(4), 7'd3, 7'd9, 2'b01, 1'b1);
      wkValid = '0;
      wkTag   = '0;
      checkOutput("t3_bypass_issue", 32'(issueValid), 32'd1);
      waitDrain(5);

      // Fill to 7, ignored enqueue, then issue+enqueue together
      lsuBusy = 1'b1;
      applyPair(mkPay(10), mkPay(11), 1'b1);
      applyPair(mkPay(12), mkPay(13), 1'b1);
      applyPair(mkPay(14), mkPay(15), 1'b1);
      checkOutput("t4_count_six", 32'(count), 32'd6);
      checkOutput("t4_ready_at_six", 32'(enqReady), 32'd1);
      applyStimulus(mkPay(16), 7'd0, 7'd0, 2'b11, 1'b1);
      checkOutput("t4_count_seven", 32'(count), 32'd7);
      checkOutput("t4_ready_at_seven", 32'(enqReady), 32'd0);
      applyPair(mkPay(90), mkPay(91), 1'b0);
      checkOutput("t4_ignored_count", 32'(count), 32'd7);
      lsuBusy = 1'b0;
      tick();
      lsuBusy = 1'b1;
      checkOutput("t4_after_issue_count", 32'(count), 32'd6);
      checkOutput("t4_after_issue_ready", 32'(enqReady), 32'd1);
      lsuBusy = 1'b0;
      applyPair(mkPay(17), mkPay(18), 1'b1);
      lsuBusy = 1'b1;
      checkOutput("t4_enq_issue_count", 32'(count), 32'd7);
      lsuBusy = 1'b0;
      waitDrain(20);
      checkOutput("t4_drained_count", 32'(count), 32'd0);

      // LSU busy holds a ready head
      lsuBusy = 1'b1;
      applyStimulus(mkPay(20), 7'd0, 7'd0, 2'b11, 1'b1);
      for (int i = 0; i < 5; i++) begin
         checkOutput("t5_busy_hold", 32'(issueValid), 32'd0);
         tick();
      end
      checkOutput("t5_busy_count", 32'(count), 32'd1);
      lsuBusy = 1'b0;
      #1;
      checkOutput("t5_release_issue", 32'(issueValid), 32'd1);
      tick();
      checkOutput("t5_single_issue", 32'(issueValid), 32'd0);
      checkOutput("t5_count_zero", 32'(count), 32'd0);

      // Flush with a concurrent enqueue, then a wrapping stream
      lsuBusy = 1'b1;
      applyPair(mkPay(30), mkPay(31), 1'b1);
      applyPair(mkPay(32), mkPay(33), 1'b1);
      applyPair(mkPay(34), mkPay(35), 1'b1);
      checkOutput("t6_count_six", 32'(count), 32'd6);
      lsuBusy = 1'b0;
      flush   = 1'b1;
      sbq.delete();
      #1;
      checkOutput("t6_flush_issue", 32'(issueValid), 32'd0);
      applyPair(mkPay(92), mkPay(93), 1'b0);
      flush = 1'b0;
      checkOutput("t6_flush_count", 32'(count), 32'd0);
      checkOutput("t6_flush_ready", 32'(enqReady), 32'd1);
      checkOutput("t6_flush_no_issue", 32'(issueValid), 32'd0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(mkPay(100 + i), 7'd0, 7'd0, 2'b11, 1'b1);
      end
      waitDrain(10);
      checkOutput("t6_stream_count", 32'(count), 32'd0);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
